servo_pwm_gen: RTL and testbench



---
 rtl/servo_pkg.sv | 27 ++
 rtl/us_tick_gen.sv | 34 +++
 rtl/servo_pwm_gen.sv | 129 ++++++++++++
 tb/tb_servo_pwm_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and elaboration-time helpers for the servo PWM generator.
package servo_pkg;

  // Fixed-point fraction bits of the angle-to-microseconds scale factor.
  localparam int FRAC    = 10;
  // Angle command width and the width of the scale factor.
  localparam int ANGLE_W = 8;
  localparam int K_W     = 15;
  // Unsigned angle * K product; wide enough that it never overflows.
  localparam int PROD_W  = ANGLE_W + K_W;

  // Scale factor in FRAC fixed point, rounded to nearest: us per degree.
  function automatic int calc_k(input int min_us, input int max_us, input int angle_max);
    return ((max_us - min_us) * (1 << FRAC) + angle_max / 2) / angle_max;
  endfunction

  // Width of the microsecond-in-frame counter.
  function automatic int us_cnt_width(input int period_us);
    return $clog2(period_us);
  endfunction

  // Pulse width in us for a given angle; used for the reset value.
  function automatic int pulse_us_of(input int angle, input int min_us, input int k);
    return min_us + ((angle * k) >> FRAC);
  endfunction

endpackage : servo_pkg

// File: rtl/us_tick_gen.sv
// Divides the system clock down to a single-cycle tick once per microsecond.
// While en is low the prescaler is held at zero so the next tick arrives a
// full microsecond after enable rises.
module us_tick_gen #(
  parameter int CLK_HZ = 12_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic us_tick
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] presc;

  assign us_tick = en && (presc == TERM);

  // Prescaler: count 0..DIV-1 while enabled, park at zero otherwise.
  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!en || us_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule : us_tick_gen

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator. A frame of PERIOD_US microseconds carries one
// high pulse whose width is linear in the applied angle. The angle command is
// only sampled at frame wraps (optionally slew-limited), and the pulse width
// register is refreshed right after the wrap while us_cnt is zero, so a
// frame's pulse is never truncated or stretched by a command change.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int PERIOD_US  = 20000,
  parameter int MIN_US     = 500,
  parameter int MAX_US     = 2500,
  parameter int ANGLE_MAX  = 180,
  parameter int INIT_ANGLE = 90,
  parameter int STEP_DEG   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [ANGLE_W-1:0] ctrl,
  output logic               pwm_out,
  output logic [ANGLE_W-1:0] cur_angle,
  output logic               busy,
  output logic               frame_start
);

  localparam int CNT_W = us_cnt_width(PERIOD_US);
  localparam int K     = calc_k(MIN_US, MAX_US, ANGLE_MAX);
  localparam int PUL_W = $clog2(MAX_US + 1);
  localparam int CMP_W = (CNT_W > PUL_W) ? CNT_W : PUL_W;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PERIOD_US - 1);
  localparam logic [ANGLE_W-1:0] ANGLE_LIM = ANGLE_W'(ANGLE_MAX);
  localparam logic [ANGLE_W-1:0] ANGLE_RST = ANGLE_W'(INIT_ANGLE);
  localparam logic [ANGLE_W-1:0] STEP      = ANGLE_W'(STEP_DEG);
  localparam logic [K_W-1:0]     K_C       = K_W'(K);
  localparam logic [CMP_W-1:0]   PULSE_RST = CMP_W'(pulse_us_of(INIT_ANGLE, MIN_US, K));

  logic               us_tick;
  logic               wrap;
  logic [CNT_W-1:0]   us_cnt;
  logic [ANGLE_W-1:0] tgt;
  logic [ANGLE_W-1:0] next_angle;
  logic [PROD_W-1:0]  prod;
  logic [CMP_W-1:0]   pulse_us;
  logic [CMP_W-1:0]   pulse_us_r;

  us_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .us_tick (us_tick)
  );

  // Last microsecond of the frame; us_tick is already gated by en.
  assign wrap = us_tick && (us_cnt == CNT_LAST);

  // Clamp the command to the legal angle range.
  always_comb begin
    tgt = (ctrl > ANGLE_LIM) ? ANGLE_LIM : ctrl;
  end

  // Angle to apply in the next frame: jump to target, or one step toward it.
  // NOTE: next_angle gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_angle = tgt;
    if (STEP_DEG != 0) begin
      if ((tgt > cur_angle) && ((tgt - cur_angle) > STEP)) begin
        next_angle = cur_angle + STEP;
      end else if ((cur_angle > tgt) && ((cur_angle - tgt) > STEP)) begin
        next_angle = cur_angle - STEP;
      end
    end
  end

  // Angle to pulse width in us: MIN_US + (angle * K) >> FRAC.
  always_comb begin
    prod     = PROD_W'(cur_angle) * PROD_W'(K_C);
    pulse_us = CMP_W'(MIN_US) + CMP_W'(prod >> FRAC);
  end

  // Microsecond position within the frame; parked at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt <= '0;
    end else if (!en || wrap) begin
      us_cnt <= '0;
    end else if (us_tick) begin
      us_cnt <= us_cnt + CNT_W'(1);
    end
  end

  // Frame boundary: flag the new frame and take up the next angle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      cur_angle   <= ANGLE_RST;
    end else begin
      frame_start <= wrap;
      if (wrap) begin
        cur_angle <= next_angle;
      end
    end
  end

  // Registered pulse width; settles one clock after cur_angle moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_us_r <= PULSE_RST;
    end else begin
      pulse_us_r <= pulse_us;
    end
  end

  // Registered PWM output and slew-in-progress flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      pwm_out <= en && (CMP_W'(us_cnt) < pulse_us_r);
      busy    <= (cur_angle != tgt);
    end
  end

endmodule : servo_pwm_gen

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen. Two instances run in lock-step on scaled-down
// timing (2 clk per us, 300 us frame): one without slew limit, one with a
// 5 degree per frame limit. Expected angles and pulse widths come from a
// frame-level model of the clamp / slew / width rules.
module tb_servo_pwm_gen;

  localparam int CLK_HZ     = 2_000_000;
  localparam int DIV        = CLK_HZ / 1_000_000;
  localparam int PERIOD_US  = 300;
  localparam int FRAME_CLK  = PERIOD_US * DIV;
  localparam int MIN_US     = 50;
  localparam int MAX_US     = 250;
  localparam int ANGLE_MAX  = 180;
  localparam int INIT_ANGLE = 90;
  localparam int STEP_S     = 5;
  localparam int KREF       = ((MAX_US - MIN_US) * 1024 + ANGLE_MAX / 2) / ANGLE_MAX;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] ctrl, ctrl_s;
  logic       pwm_out, pwm_s;
  logic [7:0] cur_angle, cur_s;
  logic       busy, busy_s;
  logic       frame_start, frame_start_s;

  int checks   = 0;
  int failures = 0;
  int model_cur;
  int model_cur_s;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .ANGLE_MAX(ANGLE_MAX), .INIT_ANGLE(INIT_ANGLE), .STEP_DEG(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ctrl(ctrl), .pwm_out(pwm_out),
    .cur_angle(cur_angle), .busy(busy), .frame_start(frame_start)
  );

  servo_pwm_gen #(
    .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US), .MAX_US(MAX_US),
    .ANGLE_MAX(ANGLE_MAX), .INIT_ANGLE(INIT_ANGLE), .STEP_DEG(STEP_S)
  ) u_dut_slew (
    .clk(clk), .rst_n(rst_n), .en(en), .ctrl(ctrl_s), .pwm_out(pwm_s),
    .cur_angle(cur_s), .busy(busy_s), .frame_start(frame_start_s)
  );

  function automatic int clampv(input int v);
    return (v > ANGLE_MAX) ? ANGLE_MAX : v;
  endfunction

  // Angle applied after one frame wrap with target tgt.
  function automatic int slew(input int cur, input int tgt, input int step);
    int d;
    d = (tgt > cur) ? tgt - cur : cur - tgt;
    if (step == 0 || d <= step) return tgt;
    return (tgt > cur) ? cur + step : cur - step;
  endfunction

  // High time in clocks for an angle.
  function automatic int pulse_clk(input int a);
    return (MIN_US + (a * KREF) / 1024) * DIV;
  endfunction

  // One full frame starting at the current negedge (a frame_start sample or
  // the edge where reset/enable was released). Ends on the next frame start.
  task automatic frame(input string tag, input int mid_ctrl);
    int hi, hi_s, fs_mid, exp_hi, exp_hi_s;
    hi = 0; hi_s = 0; fs_mid = 0;
    exp_hi   = pulse_clk(model_cur);
    exp_hi_s = pulse_clk(model_cur_s);
    for (int i = 1; i <= FRAME_CLK; i++) begin
      @(negedge clk);
      if (i == 5) begin
        checks++;
        if (cur_angle !== 8'(model_cur)) begin
          failures++;
          $display("FAIL %s cur_angle got=%0d exp=%0d", tag, cur_angle, model_cur);
        end
        checks++;
        if (cur_s !== 8'(model_cur_s)) begin
          failures++;
          $display("FAIL %s cur_angle_slew got=%0d exp=%0d", tag, cur_s, model_cur_s);
        end
      end
      if (i == 10) begin
        checks++;
        if (busy !== (model_cur != clampv(int'(ctrl)))) begin
          failures++;
          $display("FAIL %s busy got=%0b exp=%0b", tag, busy, model_cur != clampv(int'(ctrl)));
        end
        checks++;
        if (busy_s !== (model_cur_s != clampv(int'(ctrl_s)))) begin
          failures++;
          $display("FAIL %s busy_slew got=%0b exp=%0b", tag, busy_s,
                   model_cur_s != clampv(int'(ctrl_s)));
        end
      end
      if (i == 30 && mid_ctrl >= 0) ctrl = 8'(mid_ctrl);
      if (i < FRAME_CLK) begin
        hi     += int'(pwm_out);
        hi_s   += int'(pwm_s);
        fs_mid += int'(frame_start | frame_start_s);
      end
    end
    checks++;
    if (hi != exp_hi) begin
      failures++;
      $display("FAIL %s high_clk got=%0d exp=%0d", tag, hi, exp_hi);
    end
    checks++;
    if (hi_s != exp_hi_s) begin
      failures++;
      $display("FAIL %s high_clk_slew got=%0d exp=%0d", tag, hi_s, exp_hi_s);
    end
    checks++;
    if (fs_mid != 0) begin
      failures++;
      $display("FAIL %s frame_start_mid got=%0d exp=0", tag, fs_mid);
    end
    checks++;
    if (frame_start !== 1'b1 || frame_start_s !== 1'b1) begin
      failures++;
      $display("FAIL %s frame_start_end got=%0b/%0b exp=1/1", tag, frame_start, frame_start_s);
    end
    model_cur   = slew(model_cur, clampv(int'(ctrl)), 0);
    model_cur_s = slew(model_cur_s, clampv(int'(ctrl_s)), STEP_S);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; ctrl = 8'd90; ctrl_s = 8'd90;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0 || frame_start !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got pwm=%0b fs=%0b busy=%0b exp=0/0/0", pwm_out, frame_start, busy);
    end
    checks++;
    if (cur_angle !== 8'(INIT_ANGLE) || cur_s !== 8'(INIT_ANGLE)) begin
      failures++;
      $display("FAIL reset_angle got=%0d/%0d exp=%0d", cur_angle, cur_s, INIT_ANGLE);
    end
    rst_n = 1'b1;
    model_cur = INIT_ANGLE; model_cur_s = INIT_ANGLE;
    frame("init", -1);
    frame("steady90", -1);
  endtask

  task automatic test_angles();
    int vals[3] = '{0, 180, 1};
    foreach (vals[k]) begin
      ctrl = 8'(vals[k]);
      frame("angle_old", -1);
      frame("angle_new", -1);
    end
  endtask

  task automatic test_clamp();
    ctrl = 8'd200;
    frame("clamp_a", -1);
    frame("clamp_b", -1);
  endtask

  task automatic test_slew();
    ctrl_s = 8'd102;
    repeat (4) frame("slew", -1);
  endtask

  task automatic test_random();
    repeat (4) begin
      ctrl   = 8'($urandom_range(0, 255));
      ctrl_s = 8'($urandom_range(0, 255));
      frame("random", -1);
    end
  endtask

  task automatic test_en_toggle();
    int hi_off, fs_off;
    ctrl = 8'd0;
    frame("en_prep_a", -1);
    frame("en_prep_b", -1);
    frame("ctrl_mid_pulse", 180);
    repeat (100) @(negedge clk);
    en = 1'b0;
    hi_off = 0; fs_off = 0;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (i == 200) ctrl = 8'd30;
      hi_off += int'(pwm_out | pwm_s);
      fs_off += int'(frame_start | frame_start_s);
    end
    checks++;
    if (hi_off != 0 || fs_off != 0) begin
      failures++;
      $display("FAIL en_off_quiet got pwm_hi=%0d fs=%0d exp=0/0", hi_off, fs_off);
    end
    checks++;
    if (cur_angle !== 8'(model_cur)) begin
      failures++;
      $display("FAIL en_off_hold got=%0d exp=%0d", cur_angle, model_cur);
    end
    en = 1'b1;
    frame("reenable", -1);
    frame("after_en", -1);
  endtask

  task automatic test_reset_mid();
    ctrl = 8'd180;
    frame("pre_rst", -1);
    repeat (50) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_high got=%0b exp=1", pwm_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 1'b0 || pwm_s !== 1'b0 || cur_angle !== 8'(INIT_ANGLE)) begin
      failures++;
      $display("FAIL rst_async got pwm=%0b/%0b angle=%0d exp=0/0/%0d", pwm_out, pwm_s, cur_angle, INIT_ANGLE);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_cur = INIT_ANGLE; model_cur_s = INIT_ANGLE;
    frame("post_reset", -1);
    frame("post_reset_next", -1);
  endtask

  initial begin
    test_reset();
    test_angles();
    test_clamp();
    test_slew();
    test_random();
    test_en_toggle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_servo_pwm_gen
